csr_reg_file: RTL and testbench
===============================

# csr_reg_file

Machine-mode CSR storage for the Alioth core, directly downstream of the execute-stage CSR unit. It consumes that unit's write request (`csr_we`, `csr_waddr`, `csr_wdata`) and supplies the combinational `csr_rdata` the unit uses for read-modify-write and rd writeback. It also holds the 64-bit cycle and instret counters, and applies trap entry and `mret` updates from the commit/trap logic.

## Interface
- `HART_ID`, default 0: value returned by `mhartid`.
- `RESET_MTVEC`, default 32'h0000_0000: reset value of `mtvec`; bits [1:0] are forced to 0.
- `MISA_VAL`, default 32'h4000_1100 (RV32IM): constant returned by `misa`.

- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `csr_raddr_i`  in  `BUS_ADDR_WIDTH`  read address; bits [11:0] are decoded.
- `csr_rdata_o`  out  `REG_DATA_WIDTH`  combinational read data.
- `csr_we_i`  in  1  write enable from the CSR unit.
- `csr_waddr_i`  in  `BUS_ADDR_WIDTH`  write address; bits [11:0] are decoded.
- `csr_wdata_i`  in  `REG_DATA_WIDTH`  write data, already merged (RW/RS/RC).
- `inst_retire_i`  in  1  one instruction retired this cycle.
- `trap_i`  in  1  trap entry this cycle.
- `trap_cause_i`  in  32  value written to `mcause`.
- `trap_epc_i`  in  32  value written to `mepc`.
- `trap_tval_i`  in  32  value written to `mtval`.
- `mret_i`  in  1  `mret` commits this cycle.
- `irq_ext_i`, `irq_timer_i`, `irq_soft_i`  in  1 each  pending levels shown in `mip`.
- `mtvec_o`, `mepc_o`  out  32  registered values.
- `global_int_en_o`  out  1  `mstatus.MIE`.
- `int_pending_o`  out  1  OR of (`mip` & `mie`) over bits 11, 7 and 3.

## Operation
- Implemented CSRs: `mstatus` 300, `misa` 301, `mie` 304, `mtvec` 305, `mscratch` 340, `mepc` 341, `mcause` 342, `mtval` 343, `mip` 344, `mcycle`/`mcycleh` B00/B80, `minstret`/`minstreth` B02/B82, `mhartid` F14.
- Any other address: reads return 0 and writes are ignored.
- `mstatus`: only MIE[3] and MPIE[7] are writable. MPP[12:11] is hardwired to 2'b11. All other bits read 0.
- `mie`: only bits 11, 7 and 3 are writable; all other bits read 0.
- `mip`: read-only. Bit 11 reflects `irq_ext_i`, bit 7 `irq_timer_i`, bit 3 `irq_soft_i`. Writes are ignored.
- `mtvec`: direct mode only. Bits [1:0] are written as 0.
- `mepc`: bits [1:0] are written as 0 on both the CSR write path and the trap path.
- `misa` and `mhartid`: read-only constants.
- Trap entry: MPIE←MIE, MIE←0, `mepc`←`trap_epc_i`, `mcause`←`trap_cause_i`, `mtval`←`trap_tval_i`.
- `mret`: MIE←MPIE, MPIE←1.
- Priority, highest first: `trap_i`, then `mret_i`, then `csr_we_i`. A lower-priority write to a CSR that the higher-priority event also updates is dropped that cycle. Writes to CSRs the event does not touch still take effect.
- `mcycle` (64-bit): increments every cycle and wraps from all-ones to 0. In a cycle where either half is written, the written half takes the new value, the other half holds, and there is no increment.
- `minstret` (64-bit): increments when `inst_retire_i` is high. A write to either half follows the same rule as `mcycle`, and the retire pulse in that cycle is lost.

## Timing
- Reads are combinational and have no bypass: a read of the address being written in the same cycle returns the old value.
- Writes, trap updates and `mret` updates are visible on `csr_rdata_o`, `mtvec_o`, `mepc_o` and `global_int_en_o` the next cycle.
- `int_pending_o` is combinational from the registered `mie` and the live irq inputs.
- Reset (asynchronous, any cycle):
  - `mstatus` = 32'h0000_1800.
  - `mtvec` = `RESET_MTVEC` & ~3.
  - All other storage = 0.
  - Hence `global_int_en_o` = 0 and `mepc_o` = 0.
- Reset asserted mid-trap discards that trap's update.

## Structure
- Package `csr_pkg`:
  - 12-bit address constants `CSR_MSTATUS` … `CSR_MHARTID`.
  - `mstatus`/`mip` bit-position constants (`MSTATUS_MIE`=3, `MSTATUS_MPIE`=7, `MIP_MEIP`=11, `MIP_MTIP`=7, `MIP_MSIP`=3).
  - Writable-mask constants for `mstatus` and `mie`.
- Sub-module `csr_counter64`, instantiated twice (`mcycle`, `minstret`):
  - Inputs: `inc`, `we_lo`, `we_hi`, `wdata`.
  - Output: 64-bit count.

## Test plan
- **Reset:** release `rst_n` → `mstatus` reads 0x1800; `mtvec` reads `RESET_MTVEC`&~3; `misa` reads 0x40001100; `mhartid` reads `HART_ID`; address 0x7C0 reads 0.
- **Write masking:**
  - Write 0xFFFF_FFFF to `mstatus` → reads 0x1888.
  - Same write to `mie` → reads 0x888.
  - Same write to `mip` → `mip` still equals the irq inputs.
  - Write 0x8000_0003 to `mtvec` → reads 0x8000_0000.
- **Trap then mret:**
  - Precondition: MIE=1. Trap with cause 0x8000_0007, epc 0x100, tval 0 → next cycle `mepc`=0x100, `mcause`=0x8000_0007, MIE=0, MPIE=1.
  - `mret` → MIE=1, MPIE=1.
- **Collision:** in the same cycle raise `trap_i` (epc 0x200) and a CSR write of 0x300 to `mepc` → `mepc`=0x200.
- **Counter wrap:**
  - Write `mcycleh`=0xFFFF_FFFF, then `mcycle`=0xFFFF_FFFE → reads 0xFFFF_FFFE/0xFFFF_FFFF; two cycles later the counter reads 0/0.
  - Hold `inst_retire_i`=1 during a `minstret` write of 5 → next cycle reads 5, the cycle after reads 6.
- **Read-during-write:** `mscratch`=0xA; write 0xB while reading it in the same cycle → reads 0xA that cycle, 0xB the next.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared constants for the machine-mode CSR file
//
// Contents: bus widths, 12-bit CSR addresses, mstatus/mip bit positions,
// writable masks and the 4-byte alignment helper used by mtvec/mepc.
package csr_pkg;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int REG_DATA_WIDTH = 32;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MEIP     = 11;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MSIP     = 3;

  // Only MIE/MPIE are software-writable; MPP is hardwired to machine mode.
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

  function automatic logic [31:0] align4(input logic [31:0] v);
    return v & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with independently writable halves
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (count clears to 0)
//   inc          increment request for this cycle
//   we_lo, we_hi write low / high 32 bits with wdata
//   wdata        32-bit write data
//   count        current 64-bit value
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // A write to either half suppresses the increment for that cycle so
  // software sees exactly the value it wrote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 64'd0;
    end else if (we_lo) begin
      count[31:0] <= wdata;
    end else if (we_hi) begin
      count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_reg_file.sv
// rtl/csr_reg_file.sv - machine-mode CSR storage, counters, trap/mret updates
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   csr_raddr_i / csr_rdata_o        combinational read port (addr[11:0] decoded)
//   csr_we_i, csr_waddr_i, csr_wdata_i  write port from the CSR unit
//   inst_retire_i                    minstret increment
//   trap_i, trap_cause_i, trap_epc_i, trap_tval_i  trap entry
//   mret_i                           mret commit
//   irq_ext_i, irq_timer_i, irq_soft_i  pending levels shown in mip
//   mtvec_o, mepc_o, global_int_en_o registered state for fetch/trap logic
//   int_pending_o                    any enabled interrupt pending
module csr_reg_file
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_1100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BUS_ADDR_WIDTH-1:0] csr_raddr_i,
  output logic [REG_DATA_WIDTH-1:0] csr_rdata_o,
  input  logic                      csr_we_i,
  input  logic [BUS_ADDR_WIDTH-1:0] csr_waddr_i,
  input  logic [REG_DATA_WIDTH-1:0] csr_wdata_i,
  input  logic                      inst_retire_i,
  input  logic                      trap_i,
  input  logic [31:0]               trap_cause_i,
  input  logic [31:0]               trap_epc_i,
  input  logic [31:0]               trap_tval_i,
  input  logic                      mret_i,
  input  logic                      irq_ext_i,
  input  logic                      irq_timer_i,
  input  logic                      irq_soft_i,
  output logic [31:0]               mtvec_o,
  output logic [31:0]               mepc_o,
  output logic                      global_int_en_o,
  output logic                      int_pending_o
);

  logic [11:0] raddr;
  logic [11:0] waddr;
  logic        unused_addr_bits;

  logic [31:0] mstatus_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] mip;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  assign raddr = csr_raddr_i[11:0];
  assign waddr = csr_waddr_i[11:0];
  assign unused_addr_bits = ^{csr_raddr_i[BUS_ADDR_WIDTH-1:12],
                              csr_waddr_i[BUS_ADDR_WIDTH-1:12]};

  always_comb begin
    mip           = 32'd0;
    mip[MIP_MEIP] = irq_ext_i;
    mip[MIP_MTIP] = irq_timer_i;
    mip[MIP_MSIP] = irq_soft_i;
  end

  // Trap outranks mret, which outranks a software write. Only the CSRs the
  // winning event touches lose the software write; others still update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_FIXED;
      mie_q      <= 32'd0;
      mtvec_q    <= align4(RESET_MTVEC);
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
    end else begin
      if (trap_i) begin
        mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
        mstatus_q[MSTATUS_MIE]  <= 1'b0;
        mepc_q                  <= align4(trap_epc_i);
        mcause_q                <= trap_cause_i;
        mtval_q                 <= trap_tval_i;
      end else if (mret_i) begin
        mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
        mstatus_q[MSTATUS_MPIE] <= 1'b1;
      end

      if (csr_we_i) begin
        case (waddr)
          CSR_MSTATUS: begin
            if (!trap_i && !mret_i) begin
              mstatus_q <= (csr_wdata_i & MSTATUS_WMASK) | MSTATUS_FIXED;
            end
          end
          CSR_MIE:      mie_q      <= csr_wdata_i & MIE_WMASK;
          CSR_MTVEC:    mtvec_q    <= align4(csr_wdata_i);
          CSR_MSCRATCH: mscratch_q <= csr_wdata_i;
          CSR_MEPC: begin
            if (!trap_i) mepc_q <= align4(csr_wdata_i);
          end
          CSR_MCAUSE: begin
            if (!trap_i) mcause_q <= csr_wdata_i;
          end
          CSR_MTVAL: begin
            if (!trap_i) mtval_q <= csr_wdata_i;
          end
          default: ;
        endcase
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .we_lo (csr_we_i && (waddr == CSR_MCYCLE)),
    .we_hi (csr_we_i && (waddr == CSR_MCYCLEH)),
    .wdata (csr_wdata_i),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inst_retire_i),
    .we_lo (csr_we_i && (waddr == CSR_MINSTRET)),
    .we_hi (csr_we_i && (waddr == CSR_MINSTRETH)),
    .wdata (csr_wdata_i),
    .count (minstret)
  );

  // No write bypass: same-cycle reads see the pre-write value.
  always_comb begin
    csr_rdata_o = '0;
    case (raddr)
      CSR_MSTATUS:   csr_rdata_o = mstatus_q;
      CSR_MISA:      csr_rdata_o = MISA_VAL;
      CSR_MIE:       csr_rdata_o = mie_q;
      CSR_MTVEC:     csr_rdata_o = mtvec_q;
      CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
      CSR_MEPC:      csr_rdata_o = mepc_q;
      CSR_MCAUSE:    csr_rdata_o = mcause_q;
      CSR_MTVAL:     csr_rdata_o = mtval_q;
      CSR_MIP:       csr_rdata_o = mip;
      CSR_MCYCLE:    csr_rdata_o = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata_o = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata_o = minstret[31:0];
      CSR_MINSTRETH: csr_rdata_o = minstret[63:32];
      CSR_MHARTID:   csr_rdata_o = HART_ID;
      default:       csr_rdata_o = '0;
    endcase
  end

  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign global_int_en_o = mstatus_q[MSTATUS_MIE];
  assign int_pending_o   = |(mip & mie_q);

endmodule

// File: tb/tb_csr_reg_file.sv
// tb/tb_csr_reg_file.sv - self-checking bench for csr_reg_file
module tb_csr_reg_file;

  localparam logic [31:0] HART     = 32'd5;
  localparam logic [31:0] RST_TVEC = 32'h0000_1003;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] csr_raddr = 32'd0;
  logic [31:0] csr_rdata;
  logic        csr_we = 1'b0;
  logic [31:0] csr_waddr = 32'd0;
  logic [31:0] csr_wdata = 32'd0;
  logic        inst_retire = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] trap_cause = 32'd0;
  logic [31:0] trap_epc = 32'd0;
  logic [31:0] trap_tval = 32'd0;
  logic        mret = 1'b0;
  logic        irq_ext = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_soft = 1'b0;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        gie;
  logic        int_pending;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, held at CSR-value level.
  logic        m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addr_pool [16];

  always #10 clk = ~clk;

  csr_reg_file #(
    .HART_ID     (HART),
    .RESET_MTVEC (RST_TVEC),
    .MISA_VAL    (32'h4000_1100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_raddr_i     (csr_raddr),
    .csr_rdata_o     (csr_rdata),
    .csr_we_i        (csr_we),
    .csr_waddr_i     (csr_waddr),
    .csr_wdata_i     (csr_wdata),
    .inst_retire_i   (inst_retire),
    .trap_i          (trap),
    .trap_cause_i    (trap_cause),
    .trap_epc_i      (trap_epc),
    .trap_tval_i     (trap_tval),
    .mret_i          (mret),
    .irq_ext_i       (irq_ext),
    .irq_timer_i     (irq_timer),
    .irq_soft_i      (irq_soft),
    .mtvec_o         (mtvec_o),
    .mepc_o          (mepc_o),
    .global_int_en_o (gie),
    .int_pending_o   (int_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0;
    m_mie_reg = 32'd0; m_mtvec = 32'h0000_1000; m_mscratch = 32'd0;
    m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0;
    m_cycle = 64'd0; m_instret = 64'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      12'h301: return 32'h4000_1100;
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (irq_ext ? 32'h800 : 32'h0) + (irq_timer ? 32'h80 : 32'h0) +
                      (irq_soft ? 32'h8 : 32'h0);
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      12'hF14: return HART;
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the architectural rules, applied to the reference state.
  task automatic model_step();
    logic cyc_w, ins_w;
    logic [11:0] a;
    cyc_w = 1'b0; ins_w = 1'b0;
    a = csr_waddr[11:0];
    if (trap) begin
      m_mpie = m_mie; m_mie = 1'b0;
      m_mepc = trap_epc & 32'hFFFF_FFFC; m_mcause = trap_cause; m_mtval = trap_tval;
    end else if (mret) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end
    if (csr_we) begin
      if (a == 12'h300 && !trap && !mret) begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
      if (a == 12'h304) m_mie_reg = csr_wdata & 32'h888;
      if (a == 12'h305) m_mtvec = csr_wdata & 32'hFFFF_FFFC;
      if (a == 12'h340) m_mscratch = csr_wdata;
      if (a == 12'h341 && !trap) m_mepc = csr_wdata & 32'hFFFF_FFFC;
      if (a == 12'h342 && !trap) m_mcause = csr_wdata;
      if (a == 12'h343 && !trap) m_mtval = csr_wdata;
      if (a == 12'hB00) begin m_cycle = {m_cycle[63:32], csr_wdata}; cyc_w = 1'b1; end
      if (a == 12'hB80) begin m_cycle = {csr_wdata, m_cycle[31:0]}; cyc_w = 1'b1; end
      if (a == 12'hB02) begin m_instret = {m_instret[63:32], csr_wdata}; ins_w = 1'b1; end
      if (a == 12'hB82) begin m_instret = {csr_wdata, m_instret[31:0]}; ins_w = 1'b1; end
    end
    if (!cyc_w) m_cycle = m_cycle + 64'd1;
    if (!ins_w && inst_retire) m_instret = m_instret + 64'd1;
  endtask

  // Compare everything against the model, then advance one clock.
  task automatic tick();
    logic pend;
    #1;
    pend = (m_mie_reg[11] & irq_ext) | (m_mie_reg[7] & irq_timer) | (m_mie_reg[3] & irq_soft);
    check("rdata", csr_rdata, model_read(csr_raddr[11:0]));
    check("mtvec_o", mtvec_o, m_mtvec);
    check("mepc_o", mepc_o, m_mepc);
    check("gie", {31'd0, gie}, {31'd0, m_mie});
    check("int_pending", {31'd0, int_pending}, {31'd0, pend});
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_raddr = {20'd0, a};
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic idle();
    csr_we = 1'b0; trap = 1'b0; mret = 1'b0; inst_retire = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_waddr = {20'd0, a}; csr_wdata = d;
  endtask

  initial begin
    addr_pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h302};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    peek("rst_mstatus", 12'h300, 32'h0000_1800);
    peek("rst_mtvec", 12'h305, 32'h0000_1000);
    peek("rst_misa", 12'h301, 32'h4000_1100);
    peek("rst_mhartid", 12'hF14, 32'd5);
    peek("rst_unimpl", 12'h7C0, 32'd0);
    peek("rst_mcycle", 12'hB00, 32'd0);
    check("rst_mtvec_o", mtvec_o, 32'h0000_1000);
    check("rst_mepc_o", mepc_o, 32'd0);
    check("rst_gie", {31'd0, gie}, 32'd0);

    // Write masking
    wr(12'h300, 32'hFFFF_FFFF); tick(); idle();
    peek("mask_mstatus", 12'h300, 32'h0000_1888);
    check("mask_gie", {31'd0, gie}, 32'd1);
    wr(12'h304, 32'hFFFF_FFFF); tick(); idle();
    peek("mask_mie", 12'h304, 32'h0000_0888);
    irq_ext = 1'b1; irq_timer = 1'b0; irq_soft = 1'b1;
    wr(12'h344, 32'hFFFF_FFFF); tick(); idle();
    peek("mask_mip", 12'h344, 32'h0000_0808);
    check("mask_pending", {31'd0, int_pending}, 32'd1);
    wr(12'h305, 32'h8000_0003); tick(); idle();
    peek("mask_mtvec", 12'h305, 32'h8000_0000);
    check("mask_mtvec_o", mtvec_o, 32'h8000_0000);
    irq_ext = 1'b0; irq_soft = 1'b0;

    // Trap then mret
    trap = 1'b1; trap_cause = 32'h8000_0007; trap_epc = 32'h100; trap_tval = 32'd0;
    tick(); idle();
    peek("trap_mepc", 12'h341, 32'h0000_0100);
    peek("trap_mcause", 12'h342, 32'h8000_0007);
    peek("trap_mstatus", 12'h300, 32'h0000_1880);
    check("trap_mepc_o", mepc_o, 32'h0000_0100);
    check("trap_gie", {31'd0, gie}, 32'd0);
    mret = 1'b1; tick(); idle();
    peek("mret_mstatus", 12'h300, 32'h0000_1888);
    check("mret_gie", {31'd0, gie}, 32'd1);

    // Collisions
    trap = 1'b1; trap_epc = 32'h200; wr(12'h341, 32'h300); tick(); idle();
    peek("coll_mepc", 12'h341, 32'h0000_0200);
    mret = 1'b1; wr(12'h300, 32'd0); tick(); idle();
    peek("coll_mret_mstatus", 12'h300, 32'h0000_1888);
    trap = 1'b1; trap_epc = 32'h207; wr(12'h340, 32'h55); tick(); idle();
    peek("coll_mscratch", 12'h340, 32'h0000_0055);
    peek("coll_mepc_align", 12'h341, 32'h0000_0204);

    // Counter wrap
    wr(12'hB80, 32'hFFFF_FFFF); tick();
    wr(12'hB00, 32'hFFFF_FFFE); tick(); idle();
    peek("wrap_lo_set", 12'hB00, 32'hFFFF_FFFE);
    peek("wrap_hi_set", 12'hB80, 32'hFFFF_FFFF);
    tick(); tick();
    peek("wrap_lo_zero", 12'hB00, 32'd0);
    peek("wrap_hi_zero", 12'hB80, 32'd0);

    // minstret write swallows the retire pulse
    inst_retire = 1'b1; wr(12'hB02, 32'd5); tick(); csr_we = 1'b0;
    peek("instret_wr", 12'hB02, 32'd5);
    tick(); idle();
    peek("instret_inc", 12'hB02, 32'd6);
    peek("instret_hi", 12'hB82, 32'd0);

    // Read during write
    wr(12'h340, 32'hA); tick(); idle();
    wr(12'h340, 32'hB);
    peek("rdw_old", 12'h340, 32'h0000_000A);
    tick(); idle();
    peek("rdw_new", 12'h340, 32'h0000_000B);

    // Asynchronous reset during a trap discards it
    trap = 1'b1; trap_epc = 32'h300; wr(12'h340, 32'h77);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_mepc_o", mepc_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    peek("rst_trap_mepc", 12'h341, 32'd0);
    peek("rst_trap_mscratch", 12'h340, 32'd0);
    peek("rst_trap_mstatus", 12'h300, 32'h0000_1800);
    peek("rst_trap_mtvec", 12'h305, 32'h0000_1000);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      csr_raddr   = ($urandom() & 32'hFFFF_F000) |
                    {20'd0, addr_pool[$urandom_range(0, 15)]};
      csr_we      = ($urandom_range(0, 1) == 1);
      csr_waddr   = ($urandom() & 32'hFFFF_F000) |
                    {20'd0, addr_pool[$urandom_range(0, 15)]};
      csr_wdata   = $urandom();
      trap        = ($urandom_range(0, 7) == 0);
      mret        = ($urandom_range(0, 7) == 0);
      trap_cause  = $urandom();
      trap_epc    = $urandom();
      trap_tval   = $urandom();
      inst_retire = ($urandom_range(0, 1) == 1);
      irq_ext     = ($urandom_range(0, 1) == 1);
      irq_timer   = ($urandom_range(0, 1) == 1);
      irq_soft    = ($urandom_range(0, 1) == 1);
      tick();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
